// File: rtl/kl_pipe_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline.
// Control-word field positions, inst_type indices, vsel codes, WB FSM states.
package kl_pipe_pkg;

  localparam int CTL_W   = 22;
  localparam int OPC_HI  = 21;
  localparam int OPC_LO  = 19;
  localparam int OP_HI   = 18;
  localparam int OP_LO   = 17;
  localparam int WNUM_HI = 16;
  localparam int WNUM_LO = 14;
  localparam int WRITE_B = 13;
  localparam int VSEL_HI = 12;
  localparam int VSEL_LO = 11;
  localparam int LOADS_B = 8;

  localparam int IT_W    = 6;
  localparam int IT_ALU  = 0;
  localparam int IT_STR  = 1;
  localparam int IT_LDR  = 2;
  localparam int IT_BR   = 3;
  localparam int IT_LINK = 4;
  localparam int IT_HALT = 5;

  typedef enum logic [1:0] {
    VSEL_RES  = 2'b00,
    VSEL_MEM  = 2'b01,
    VSEL_PC   = 2'b10,
    VSEL_ZERO = 2'b11
  } vsel_e;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/pipeline_4_wrback_wb_select.sv
// Writeback data mux and register-file write qualification.
// Ports: vsel, result/rdata/pc1 sources, write/bubble/run/stall -> wen, wdata.
module wb_select
  import kl_pipe_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [1:0]    vsel,
  input  logic [DW-1:0] result,
  input  logic [DW-1:0] rdata,
  input  logic [DW-1:0] pc1,
  input  logic          write,
  input  logic          bubble,
  input  logic          run,
  input  logic          stall,
  output logic          wen,
  output logic [DW-1:0] wdata
);

  always_comb begin
    wdata = '0;
    unique case (vsel_e'(vsel))
      VSEL_RES:  wdata = result;
      VSEL_MEM:  wdata = rdata;
      VSEL_PC:   wdata = pc1;
      VSEL_ZERO: wdata = '0;
      default:   wdata = '0;
    endcase
  end

  assign wen = write & ~bubble & run & ~stall;

endmodule

// File: rtl/vdff_en.sv
// Enabled register cell with asynchronous active-low clear.
// Ports: clk, rst (active-low), en, d -> q.
module vdff_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/pipeline_4_wrback.sv
// Writeback stage: latches mem-stage bundle, drives regfile/forwarding,
// status flags, HALT FSM and retired counter. Ports per stage interface.
module pipeline_4_wrback
  import kl_pipe_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 9,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [21:0]     control_in,
  input  logic [5:0]      inst_type_in,
  input  logic [DW-1:0]   result_in,
  input  logic [AW-1:0]   pc_in,
  input  logic            N_in,
  input  logic            V_in,
  input  logic            Z_in,
  input  logic [DW-1:0]   rdata_mem,
  output logic            reg_wen,
  output logic [2:0]      reg_waddr,
  output logic [DW-1:0]   reg_wdata,
  output logic            fwd_valid,
  output logic [2:0]      fwd_reg,
  output logic [DW-1:0]   fwd_data,
  output logic            status_N,
  output logic            status_V,
  output logic            status_Z,
  output logic            halted,
  output logic [CNTW-1:0] retired_count
);

  wb_state_e state_q, state_d;

  logic            run;
  logic            cap;
  logic [21:0]     ctl_q;
  logic [5:0]      it_q;
  logic [DW-1:0]   res_q;
  logic [DW-1:0]   pc1_q;
  logic [AW-1:0]   pc_inc;
  logic [DW-1:0]   pc1_d;
  logic [2:0]      nvz_q;
  logic [CNTW-1:0] cnt_d;

  assign run = (state_q == RUN);
  assign cap = run & ~stall;

  assign pc_inc = pc_in + AW'(1);
  assign pc1_d  = {{(DW-AW){1'b0}}, pc_inc};
  assign cnt_d  = retired_count + CNTW'(1);

  vdff_en #(.W(22)) u_ctl (
    .clk(clk), .rst(rst), .en(cap),
    .d(control_in), .q(ctl_q)
  );

  vdff_en #(.W(6)) u_it (
    .clk(clk), .rst(rst), .en(cap),
    .d(inst_type_in), .q(it_q)
  );

  vdff_en #(.W(DW)) u_res (
    .clk(clk), .rst(rst), .en(cap),
    .d(result_in), .q(res_q)
  );

  vdff_en #(.W(DW)) u_pc1 (
    .clk(clk), .rst(rst), .en(cap),
    .d(pc1_d), .q(pc1_q)
  );

  vdff_en #(.W(3)) u_st (
    .clk(clk), .rst(rst),
    .en(cap & control_in[LOADS_B]),
    .d({N_in, V_in, Z_in}), .q(nvz_q)
  );

  // Counts on capture of any non-bubble, so HALT retires too.
  vdff_en #(.W(CNTW)) u_cnt (
    .clk(clk), .rst(rst),
    .en(cap & (|inst_type_in)),
    .d(cnt_d), .q(retired_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (it_q[IT_HALT] && !stall)
                 state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  wb_select #(.DW(DW)) u_sel (
    .vsel(ctl_q[VSEL_HI:VSEL_LO]),
    .result(res_q),
    .rdata(rdata_mem),
    .pc1(pc1_q),
    .write(ctl_q[WRITE_B]),
    .bubble(it_q == 6'b0),
    .run(run),
    .stall(stall),
    .wen(reg_wen),
    .wdata(reg_wdata)
  );

  assign reg_waddr = ctl_q[WNUM_HI:WNUM_LO];
  assign fwd_valid = reg_wen;
  assign fwd_reg   = reg_waddr;
  assign fwd_data  = reg_wdata;

  assign {status_N, status_V, status_Z} = nvz_q;
  assign halted = (state_q == HALTED);

endmodule
